// File: rtl/i2c_wb_arbiter.sv
// Shares the I2C core's Wishbone slave between two masters; a START write locks the core until trans_comp.
// Grant one cycle after request, then a zero-latency combinational data/ack path; the non-owner stalls with no ack.
module i2c_wb_arbiter #(
    parameter int              AW           = 3,
    parameter int              DW           = 8,
    parameter logic [AW-1:0]   CMD_ADDR     = AW'(2),
    parameter int              START_BIT    = 7,
    parameter int              LOCK_TIMEOUT = 65535
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [AW-1:0] m0_add_i,
    input  logic [DW-1:0] m0_data_i,
    input  logic          m0_we_i,
    input  logic          m0_stb_i,
    input  logic          m0_cyc_i,
    output logic [DW-1:0] m0_data_o,
    output logic          m0_ack_o,
    output logic          m0_irq_o,
    output logic          m0_trans_comp_o,
    input  logic [AW-1:0] m1_add_i,
    input  logic [DW-1:0] m1_data_i,
    input  logic          m1_we_i,
    input  logic          m1_stb_i,
    input  logic          m1_cyc_i,
    output logic [DW-1:0] m1_data_o,
    output logic          m1_ack_o,
    output logic          m1_irq_o,
    output logic          m1_trans_comp_o,
    output logic [AW-1:0] s_add_o,
    output logic [DW-1:0] s_data_o,
    output logic          s_we_o,
    output logic          s_stb_o,
    output logic          s_cyc_o,
    input  logic [DW-1:0] s_data_i,
    input  logic          s_ack_i,
    input  logic          s_irq_i,
    input  logic          s_trans_comp_i,
    output logic          timeout_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, HOLD = 2'd2} state_t;

    localparam int             TW     = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [TW-1:0]  T_LAST = TW'(LOCK_TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          pending_q, pending_d;
    logic          timeout_q, timeout_d;
    logic [TW-1:0] tcnt_q, tcnt_d;

    logic [AW-1:0] own_add;
    logic [DW-1:0] own_data;
    logic          own_we, own_stb, own_cyc, arm;

    assign own_add  = owner_q ? m1_add_i  : m0_add_i;
    assign own_data = owner_q ? m1_data_i : m0_data_i;
    assign own_we   = owner_q ? m1_we_i   : m0_we_i;
    assign own_stb  = owner_q ? m1_stb_i  : m0_stb_i;
    assign own_cyc  = owner_q ? m1_cyc_i  : m0_cyc_i;

    // An acked command write with START set means the core is now busy on the owner's behalf.
    assign arm = own_stb & own_we & s_ack_i & (own_add == CMD_ADDR) & own_data[START_BIT];

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            pending_q <= 1'b0;
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            pending_q <= pending_d;
            tcnt_q    <= tcnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        pending_d = pending_q;
        tcnt_d    = '0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i | m1_cyc_i) begin
                    owner_d = (m0_cyc_i & m1_cyc_i) ? ~last_q : m1_cyc_i;
                    last_d  = owner_d;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (arm)
                    pending_d = 1'b1;
                if (s_trans_comp_i)
                    pending_d = 1'b0;
                if (!own_cyc)
                    state_d = pending_d ? HOLD : IDLE;
            end
            HOLD: begin
                if (s_trans_comp_i) begin
                    state_d   = IDLE;
                    pending_d = 1'b0;
                end else if (own_cyc) begin
                    state_d = BUS;
                end else if (tcnt_q == T_LAST) begin
                    state_d   = IDLE;
                    pending_d = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_add_o   = '0;
        s_data_o  = '0;
        s_we_o    = 1'b0;
        s_stb_o   = 1'b0;
        s_cyc_o   = 1'b0;
        m0_data_o = '0;
        m0_ack_o  = 1'b0;
        m1_data_o = '0;
        m1_ack_o  = 1'b0;
        if (state_q == BUS) begin
            s_add_o  = own_add;
            s_data_o = own_data;
            s_we_o   = own_we;
            s_stb_o  = own_stb;
            s_cyc_o  = own_cyc;
            if (owner_q) begin
                m1_data_o = s_data_i;
                m1_ack_o  = s_ack_i;
            end else begin
                m0_data_o = s_data_i;
                m0_ack_o  = s_ack_i;
            end
        end
    end

    // Owner is kept through IDLE so a late irq/trans_comp still reaches whoever launched the transfer.
    assign m0_irq_o        = s_irq_i & ~owner_q;
    assign m1_irq_o        = s_irq_i &  owner_q;
    assign m0_trans_comp_o = s_trans_comp_i & ~owner_q;
    assign m1_trans_comp_o = s_trans_comp_i &  owner_q;
    assign timeout_o       = timeout_q;

endmodule
